// File: rtl/data_select_arbiter.sv
// Two-requester arbiter driving a shared 1-bit data output, with LAST-based tie-breaking
// and a saturating HOLD counter that forces a turnover when the other side is waiting.
module data_select_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_i,
  input  logic b_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output logic sel_o,
  output logic q_o
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;   // 0 = A served last, 1 = B served last
  logic [HW-1:0] hold_q, hold_d;
  logic          sel_q, sel_d;
  logic          q_q, q_d;
  logic          gnt_a_q, gnt_b_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    q_d     = (state_q == IDLE) ? 1'b0 : (sel_q ? b_i : a_i);
    case (state_q)
      IDLE: begin
        if (req_a_i && req_b_i) state_d = last_q ? OWN_A : OWN_B;
        else if (req_a_i)       state_d = OWN_A;
        else if (req_b_i)       state_d = OWN_B;
      end
      OWN_A: begin
        if (!req_a_i)                           state_d = req_b_i ? OWN_B : IDLE;
        else if (req_b_i && hold_q == HOLD_MAX) state_d = OWN_B;
        else if (hold_q != HOLD_MAX)            hold_d  = hold_q + HOLD_ONE;
      end
      OWN_B: begin
        if (!req_b_i)                           state_d = req_a_i ? OWN_A : IDLE;
        else if (req_a_i && hold_q == HOLD_MAX) state_d = OWN_A;
        else if (hold_q != HOLD_MAX)            hold_d  = hold_q + HOLD_ONE;
      end
      default: state_d = IDLE;
    endcase
    // Any entry into an owner state restarts the run and moves the select with the grant.
    if (state_d != state_q && state_d != IDLE) begin
      hold_d = HOLD_ONE;
      last_d = (state_d == OWN_B);
      sel_d  = (state_d == OWN_B);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      sel_q   <= 1'b0;
      q_q     <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      q_q     <= q_d;
      gnt_a_q <= (state_d == OWN_A);
      gnt_b_q <= (state_d == OWN_B);
    end
  end

  assign gnt_a_o = gnt_a_q;
  assign gnt_b_o = gnt_b_q;
  assign sel_o   = sel_q;
  assign q_o     = q_q;

endmodule
